// File: rtl/monitor_semaforo.sv
// Traffic-light sequence monitor: locks onto A-B-C-D, checks phase lengths and order.
// Latency: every output is registered and reflects the luces sample of the same edge.
// Backpressure: none; luces is sampled every rising edge unconditionally.
module monitor_semaforo #(
  parameter int unsigned T_A = 15,
  parameter int unsigned T_B = 10,
  parameter int unsigned T_C = 15,
  parameter int unsigned T_D = 10
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic [7:0] luces_i,
  input  logic       borrar_i,
  output logic [1:0] fase_o,
  output logic       valido_o,
  output logic [7:0] ciclos_o,
  output logic       pulso_fase_o,
  output logic [7:0] vueltas_o,
  output logic       error_o,
  output logic [2:0] cod_error_o
);

  localparam logic [7:0] PAT_A = 8'b10000001;
  localparam logic [7:0] PAT_B = 8'b10000010;
  localparam logic [7:0] PAT_C = 8'b00100100;
  localparam logic [7:0] PAT_D = 8'b01000100;

  localparam logic [2:0] COD_NONE    = 3'd0;
  localparam logic [2:0] COD_ILEGAL  = 3'd1;
  localparam logic [2:0] COD_ORDEN   = 3'd2;
  localparam logic [2:0] COD_CORTO   = 3'd3;
  localparam logic [2:0] COD_LARGO   = 3'd4;

  typedef enum logic {ESPERA = 1'b0, SEGUIR = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] prev_q;
  logic [1:0] fase_q, fase_d;
  logic [7:0] ciclos_q, ciclos_d;
  logic       pulso_q, pulso_d;
  logic [7:0] vueltas_q, vueltas_d;
  logic       error_q, error_d;
  logic [2:0] cod_q, cod_d;

  logic       legal;
  logic       cambio;
  logic [7:0] pat_next;
  logic [7:0] t_cur;
  logic [2:0] codigo;
  logic       err_base;
  logic [2:0] cod_base;

  // Successor pattern and required length of the phase currently tracked.
  always_comb begin
    pat_next = PAT_B;
    t_cur    = 8'(T_A);
    case (fase_q)
      2'd0: begin pat_next = PAT_B; t_cur = 8'(T_A); end
      2'd1: begin pat_next = PAT_C; t_cur = 8'(T_B); end
      2'd2: begin pat_next = PAT_D; t_cur = 8'(T_C); end
      default: begin pat_next = PAT_A; t_cur = 8'(T_D); end
    endcase
  end

  // Run-length counter: restarts on any pattern change, saturates at 255.
  always_comb begin
    legal  = (luces_i == PAT_A) || (luces_i == PAT_B) ||
             (luces_i == PAT_C) || (luces_i == PAT_D);
    cambio = (luces_i != prev_q);
    if (cambio)                ciclos_d = 8'd1;
    else if (ciclos_q == 8'hFF) ciclos_d = 8'hFF;
    else                       ciclos_d = ciclos_q + 8'd1;
  end

  // Lock/track FSM: fault classification, phase advance and round counting.
  always_comb begin
    state_d   = state_q;
    fase_d    = fase_q;
    pulso_d   = 1'b0;
    vueltas_d = vueltas_q;
    codigo    = COD_NONE;
    case (state_q)
      ESPERA: begin
        // Only a fresh A start locks; a held A just keeps waiting.
        if (luces_i == PAT_A && cambio) begin
          state_d = SEGUIR;
          fase_d  = 2'd0;
        end else if (luces_i != 8'h00 && !legal) begin
          codigo = COD_ILEGAL;
        end
      end
      default: begin
        if (!legal) begin
          codigo = COD_ILEGAL;
        end else if (!cambio) begin
          // ciclos rises by one per held cycle, so T+1 is hit exactly once per run.
          if ({1'b0, ciclos_d} == ({1'b0, t_cur} + 9'd1)) codigo = COD_LARGO;
        end else if (luces_i != pat_next) begin
          codigo = COD_ORDEN;
        end else if (ciclos_q < t_cur) begin
          codigo = COD_CORTO;
        end else begin
          fase_d  = fase_q + 2'd1;
          pulso_d = 1'b1;
          if (fase_q == 2'd3) vueltas_d = vueltas_q + 8'd1;
        end
        if (codigo == COD_ILEGAL || codigo == COD_ORDEN || codigo == COD_CORTO) begin
          state_d = ESPERA;
          fase_d  = 2'd0;
        end
      end
    endcase
  end

  // Sticky error: clear applies first, so a same-edge fault re-arms with its own code.
  always_comb begin
    err_base = borrar_i ? 1'b0 : error_q;
    cod_base = borrar_i ? 3'd0 : cod_q;
    error_d  = err_base;
    cod_d    = cod_base;
    if (codigo != COD_NONE) begin
      error_d = 1'b1;
      if (!err_base) cod_d = codigo;
    end
  end

  // State and output registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ESPERA;
      prev_q    <= 8'h00;
      fase_q    <= 2'd0;
      ciclos_q  <= 8'd0;
      pulso_q   <= 1'b0;
      vueltas_q <= 8'd0;
      error_q   <= 1'b0;
      cod_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      prev_q    <= luces_i;
      fase_q    <= fase_d;
      ciclos_q  <= ciclos_d;
      pulso_q   <= pulso_d;
      vueltas_q <= vueltas_d;
      error_q   <= error_d;
      cod_q     <= cod_d;
    end
  end

  assign fase_o       = fase_q;
  assign valido_o     = (state_q == SEGUIR);
  assign ciclos_o     = ciclos_q;
  assign pulso_fase_o = pulso_q;
  assign vueltas_o    = vueltas_q;
  assign error_o      = error_q;
  assign cod_error_o  = cod_q;

endmodule
